// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - 8-source prioritized interrupt controller with register window
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   din, address    bus write data / address (window BASE..BASE+5)
//   w_en, r_en      bus write / read strobes
//   dout            registered bus read data
//   src             asynchronous interrupt sources
//   int_ack         one-cycle CPU acknowledge
//   irq             registered interrupt request, high while in REQ
//   vector          index of the last acknowledged source

module interrupt_controller #(
    parameter logic [7:0] BASE = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] src,
    input  logic       int_ack,
    output logic       irq,
    output logic [2:0] vector
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] imask, ipend, iedge, ipol;
    logic [7:0] sync1, sync2, sync_prev;
    logic [7:0] edge_q;
    logic [7:0] eligible;
    logic [7:0] ack_clr;
    logic [7:0] w1c;
    logic [7:0] pend_next;
    logic [7:0] rdata;
    logic [7:0] offset;
    logic [2:0] winner;
    logic       in_window;
    logic       wr_hit;
    logic       ack_fire;
    logic       eoi_wr;

    // Subtracting BASE first keeps the window check correct even near 8'hFF.
    assign offset    = address - BASE;
    assign in_window = (offset < 8'd6);
    assign wr_hit    = w_en && in_window;
    assign eoi_wr    = wr_hit && (offset == 8'd5);
    assign w1c       = (wr_hit && offset == 8'd1) ? din : 8'h00;

    assign eligible  = ipend & imask;

    // Fixed priority, bit 0 wins: scan from the top so the lowest set bit is last written.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
    end

    assign ack_fire = int_ack && (state == REQ) && (eligible != 8'h00);
    assign ack_clr  = ack_fire ? (8'h01 << winner) : 8'h00;

    // Edge-mode bits: clear by W1C/ack, but a set in the same cycle wins.
    // Level-mode bits simply track the synced source against polarity.
    always_comb begin
        pend_next = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (iedge[i])
                pend_next[i] = (ipend[i] & ~(w1c[i] | ack_clr[i])) | edge_q[i];
            else
                pend_next[i] = sync2[i] ~^ ipol[i];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (eligible != 8'h00) state_next = REQ;
            REQ: begin
                if (ack_fire)                state_next = SERVICE;
                else if (eligible == 8'h00)  state_next = IDLE;
            end
            SERVICE: if (eoi_wr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdata = 8'h00;
        case (offset)
            8'd0:    rdata = imask;
            8'd1:    rdata = ipend;
            8'd2:    rdata = iedge;
            8'd3:    rdata = ipol;
            8'd4:    rdata = {state, 3'b000, vector};
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imask     <= 8'h00;
            ipend     <= 8'h00;
            iedge     <= 8'h00;
            ipol      <= 8'h00;
            sync1     <= 8'h00;
            sync2     <= 8'h00;
            sync_prev <= 8'h00;
            edge_q    <= 8'h00;
            state     <= IDLE;
            irq       <= 1'b0;
            vector    <= 3'd0;
            dout      <= 8'h00;
        end else begin
            sync1     <= src;
            sync2     <= sync1;
            sync_prev <= sync2;
            edge_q    <= (sync2 & ~sync_prev & ipol) | (~sync2 & sync_prev & ~ipol);
            ipend     <= pend_next;
            state     <= state_next;
            irq       <= (state_next == REQ);
            if (ack_fire) vector <= winner;
            if (wr_hit && offset == 8'd0) imask <= din;
            if (wr_hit && offset == 8'd2) iedge <= din;
            if (wr_hit && offset == 8'd3) ipol  <= din;
            if (r_en && in_window) dout <= rdata;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;

    localparam logic [7:0] A_IMASK = 8'h10;
    localparam logic [7:0] A_IPEND = 8'h11;
    localparam logic [7:0] A_IEDGE = 8'h12;
    localparam logic [7:0] A_IPOL  = 8'h13;
    localparam logic [7:0] A_IVEC  = 8'h14;
    localparam logic [7:0] A_EOI   = 8'h15;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic [7:0] src;
    logic       int_ack;
    logic       irq;
    logic [2:0] vector;

    int vectors_applied = 0;
    int miscompares = 0;

    typedef struct {
        logic       wr;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] ra;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;

    vec_t tbl[8];
    sb_t  sbq[$];

    interrupt_controller #(.BASE(8'h10)) dut (
        .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en),
        .r_en(r_en), .dout(dout), .src(src), .int_ack(int_ack), .irq(irq),
        .vector(vector)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a; din = d; w_en = 1'b1;
        cyc();
        w_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        sb_t s;
        s.exp = e; s.name = nm;
        sbq.push_back(s);
        address = a; r_en = 1'b1;
        cyc();
        r_en = 1'b0;
        s = sbq.pop_front();
        chk(s.name, dout, s.exp);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
    endtask

    task automatic wait_irq(input int budget, output int n);
        n = 0;
        while (irq !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, A_IEDGE, 8'hFF, A_IEDGE, 8'hFF};
        tbl[1] = '{1'b1, A_IPEND, 8'hFF, A_IPEND, 8'h00};
        tbl[2] = '{1'b1, A_IMASK, 8'hA5, A_IMASK, 8'hA5};
        tbl[3] = '{1'b1, A_IPOL,  8'hC3, A_IPOL,  8'hC3};
        tbl[4] = '{1'b0, 8'h00,   8'h00, A_IVEC,  8'h00};
        tbl[5] = '{1'b1, A_EOI,   8'h12, A_EOI,   8'h00};
        tbl[6] = '{1'b1, 8'h16,   8'h77, A_IMASK, 8'hA5};
        tbl[7] = '{1'b1, 8'h0F,   8'h00, A_IEDGE, 8'hFF};

        rst = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
        src = 8'h00; int_ack = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("reset_irq", {7'b0, irq}, 8'h00);
        chk("reset_dout", dout, 8'h00);
        rd(A_IVEC, 8'h00, "reset_ivec");

        // Register map vectors
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) wr(tbl[i].wa, tbl[i].wd);
            rd(tbl[i].ra, tbl[i].exp, $sformatf("tbl%0d", i));
        end
        wr(A_IMASK, 8'h00);
        wr(A_IPOL, 8'hFF);
        wr(A_IPEND, 8'hFF);

        // Edge path on source 0, latency and ack
        wr(A_IMASK, 8'h01);
        src = 8'h01;
        wait_irq(20, n);
        chk("edge_latency", 8'(n), 8'd5);
        ack();
        chk("ack_drops_irq", {7'b0, irq}, 8'h00);
        rd(A_IVEC, 8'h80, "ivec_service_v0");
        rd(A_IPEND, 8'h00, "ipend_cleared_by_ack");
        ack();
        rd(A_IVEC, 8'h80, "ack_in_service_ignored");
        wr(A_EOI, 8'h00);
        repeat (4) cyc();
        chk("no_reraise", {7'b0, irq}, 8'h00);
        rd(A_IVEC, 8'h00, "ivec_idle_v0");
        src = 8'h00;
        repeat (5) cyc();
        rd(A_IPEND, 8'h00, "falling_ignored");

        // Priority between sources 2 and 5
        wr(A_IMASK, 8'hFF);
        src = 8'h24;
        wait_irq(20, n);
        chk("prio_irq", {7'b0, irq}, 8'h01);
        ack();
        rd(A_IVEC, 8'h82, "prio_first_v2");
        wr(A_EOI, 8'h00);
        wait_irq(6, n);
        chk("prio_reraise_latency", 8'(n), 8'd1);
        ack();
        rd(A_IVEC, 8'h85, "prio_second_v5");
        rd(A_IPEND, 8'h00, "prio_ipend_empty");
        wr(A_EOI, 8'h00);
        src = 8'h00;
        repeat (5) cyc();
        chk("prio_idle_irq", {7'b0, irq}, 8'h00);

        // W1C colliding with a set on bit 1
        wr(A_IMASK, 8'h00);
        src = 8'h02;
        repeat (3) cyc();
        wr(A_IPEND, 8'h02);
        rd(A_IPEND, 8'h02, "collision_set_wins");
        wr(A_IPEND, 8'h02);
        rd(A_IPEND, 8'h00, "w1c_clears");
        src = 8'h00;
        repeat (5) cyc();

        // Masked capture, then unmask, then withdraw
        src = 8'h10;
        repeat (6) cyc();
        rd(A_IPEND, 8'h10, "masked_capture");
        chk("masked_no_irq", {7'b0, irq}, 8'h00);
        wr(A_IMASK, 8'h10);
        wait_irq(5, n);
        chk("unmask_latency", 8'(n), 8'd1);
        wr(A_IPEND, 8'h10);
        cyc();
        chk("withdraw_irq", {7'b0, irq}, 8'h00);
        rd(A_IVEC, 8'h05, "withdraw_idle");
        src = 8'h00;
        repeat (5) cyc();

        // Level mode, active-low on source 3
        ack();
        rd(A_IVEC, 8'h05, "ack_in_idle_ignored");
        wr(A_IMASK, 8'h00);
        src = 8'hF7;
        wr(A_IEDGE, 8'h00);
        wr(A_IPOL, 8'h00);
        repeat (4) cyc();
        rd(A_IPEND, 8'h08, "level_pending");
        wr(A_IMASK, 8'h08);
        wait_irq(5, n);
        chk("level_irq", {7'b0, irq}, 8'h01);
        wr(A_IPEND, 8'h08);
        rd(A_IPEND, 8'h08, "level_w1c_no_effect");
        src = 8'hFF;
        repeat (3) cyc();
        rd(A_IPEND, 8'h00, "level_release");
        chk("level_irq_drop", {7'b0, irq}, 8'h00);
        wr(A_IMASK, 8'h00);

        // Reset while in SERVICE, with a bus write held during reset
        wr(A_IEDGE, 8'hFF);
        wr(A_IPOL, 8'hFF);
        wr(A_IPEND, 8'hFF);
        src = 8'hBF;
        repeat (3) cyc();
        src = 8'hFF;
        repeat (5) cyc();
        wr(A_IMASK, 8'h40);
        wait_irq(10, n);
        chk("svc_irq", {7'b0, irq}, 8'h01);
        ack();
        rd(A_IVEC, 8'h86, "svc_ivec_v6");
        rst = 1'b1; address = A_IMASK; din = 8'hFF; w_en = 1'b1;
        cyc();
        rst = 1'b0; w_en = 1'b0;
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_vector", {5'b0, vector}, 8'h00);
        chk("rst_dout", dout, 8'h00);
        rd(A_IMASK, 8'h00, "rst_imask_write_ignored");
        rd(A_IEDGE, 8'h00, "rst_iedge");
        rd(A_IPOL, 8'h00, "rst_ipol");
        rd(A_IVEC, 8'h00, "rst_ivec");
        rd(A_EOI, 8'h00, "rst_eoi");
        repeat (4) cyc();
        rd(A_IPEND, 8'h00, "rst_ipend");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have parameter BASE, default 8'h10, meaning the base address of the six-register window BASE..BASE+5.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
  clk  input  1  system clock; all state changes on its rising edge
  rst  input  1  synchronous, active-high reset
  din  input  8  bus write data
  address  input  8  bus address
  w_en  input  1  bus write strobe
  r_en  input  1  bus read strobe
  dout  output  8  registered bus read data
  src  input  8  asynchronous interrupt sources: pins, timer match0/match1, ...
  int_ack  input  1  one-cycle CPU acknowledge pulse
  irq  output  1  interrupt request to CPU
  vector  output  3  index of the acknowledged source

Function
REQ-003 src SHALL pass through a 2-flop synchronizer; a third flop holds the previous synced value for edge detection.
REQ-004 Register map, offset from BASE:
  0 IMASK  R/W  1 = source enabled
  1 IPEND  R; write-1-to-clear
  2 IEDGE  R/W  1 = edge mode, 0 = level mode
  3 IPOL  R/W  1 = rising/high active, 0 = falling/low active
  4 IVEC  R  {state[1:0], 3'b0, vector}
  5 EOI  W-only; any write ends service; reads return 0
REQ-005 Edge mode: pending bit i SHALL set on the cycle after a synced transition matching IPOL[i]. It SHALL stay set until IPEND W1C or acknowledge.
REQ-006 Level mode: pending bit i SHALL equal the synced src[i] XNOR IPOL[i] every cycle. W1C and acknowledge SHALL have no effect on it.
REQ-007 A pending set event and a W1C of the same bit in the same cycle SHALL leave the bit set.
REQ-008 Pending bits SHALL capture regardless of IMASK. Eligible = IPEND & IMASK.
REQ-009 Priority SHALL be fixed, bit 0 highest. The winner index SHALL be combinational from eligible.
REQ-010 State machine has three states, encoded IDLE=0, REQ=1, SERVICE=2:
  IDLE → REQ when eligible != 0
  REQ → IDLE when eligible becomes 0 before ack; irq drops
  REQ → SERVICE on int_ack
  SERVICE → IDLE on a write to EOI
REQ-011 irq SHALL be a registered output, high exactly while state is REQ.
REQ-012 On int_ack in REQ, the block SHALL:
  latch the current winner into vector
  clear that pending bit if it is in edge mode
  drop irq in the next cycle
REQ-013 int_ack outside REQ SHALL be ignored.
REQ-014 While in SERVICE, no new irq SHALL be raised (no nesting). Pending bits SHALL continue to capture.
REQ-015 After EOI, if eligible != 0 the block SHALL go back to REQ one cycle after reaching IDLE.
REQ-016 Bus reads SHALL update dout one cycle after r_en with address in the window. Otherwise dout SHALL hold its value.
REQ-017 Writes SHALL take effect on the clock edge where w_en is high. Addresses outside the window SHALL be ignored.
REQ-018 Source-to-irq latency SHALL be 5 cycles for an edge on an enabled source in IDLE: 2 sync + edge detect + pending + irq register.

Reset
REQ-019 With rst high at a clock edge, the following SHALL be 0 at the next edge:
  IMASK, IPEND, IEDGE, IPOL
  synchronizer and edge flops
  state (IDLE), irq, vector, dout
REQ-020 Reset mid-REQ or mid-SERVICE SHALL abandon the interrupt with no pending state retained. The first edge with rst low resumes normal operation.
REQ-021 Bus writes while rst is high SHALL be ignored.

Verification
REQ-022 Edge path:
  stimulus: IMASK=01, IEDGE=01, IPOL=01; src[0] rises at cycle T
  response: irq=1 at T+5; int_ack → vector=0, IPEND=00, irq=0 next cycle; EOI write → IDLE, no re-raise
REQ-023 Priority:
  stimulus: IMASK=FF, IEDGE=FF, IPOL=FF; src[5] and src[2] rise together
  response: first ack vector=2; after EOI irq re-raises; second ack vector=5
REQ-024 Level mode, active-low:
  stimulus: IEDGE=00, IPOL=00, IMASK=08; hold src[3]=0
  response: IPEND[3]=1; W1C 08 leaves it 1; src[3]=1 → IPEND[3]=0 within 3 cycles
REQ-025 W1C/set collision: W1C of bit 1 in the same cycle bit 1's edge sets it → IPEND[1] reads 1.
REQ-026 Masked and withdrawn:
  stimulus: IMASK=00, edge on src[4]
  response: IPEND=10, irq stays 0; writing IMASK=10 → irq=1 two cycles later; writing IPEND=10 before ack → irq drops, state IDLE
REQ-027 Reset in SERVICE:
  stimulus: assert rst for one cycle while in SERVICE
  response: irq=0, vector=0, all registers read 00, IVEC reads 00
